// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: opcodes, ALU function codes and width helpers for tiny_cpu_core
package tiny_cpu_pkg;

    localparam int NREG = 8;

    localparam logic [3:0] OP_ALU0 = 4'h4;
    localparam logic [3:0] OP_ALU1 = 4'h5;
    localparam logic [3:0] OP_UN   = 4'h6;
    localparam logic [3:0] OP_ROT  = 4'h7;
    localparam logic [3:0] OP_JNC  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_MVI  = 4'hA;
    localparam logic [3:0] OP_HLT  = 4'hB;

    // Encoding is {op[1:0], sub} of the 01xx opcode group.
    typedef enum logic [2:0] {
        ALU_ADD, ALU_OR, ALU_AND, ALU_XOR, ALU_INC, ALU_NOT, ALU_ROR, ALU_ROL
    } alu_fn_e;

    function automatic int imw_f(input int dw, input int aw);
        return dw > aw ? dw : aw;
    endfunction

endpackage

// File: rtl/tiny_cpu_alu.sv
// tiny_cpu_alu: combinational ALU; binary ops use a (r0) and b, unary ops use b only
// Ports: fn function select, a/b operands, y result, cout carry out (ADD/INC only)
module tiny_cpu_alu
    import tiny_cpu_pkg::*;
#(
    parameter int DW = 4
) (
    input  alu_fn_e       fn,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y,
    output logic          cout
);

    logic [DW:0] sum;

    always_comb begin
        sum  = fn == ALU_INC ? {1'b0, b} + (DW+1)'(1) : {1'b0, a} + {1'b0, b};
        y    = fn == ALU_ADD || fn == ALU_INC ? sum[DW-1:0] :
               fn == ALU_OR  ? a | b :
               fn == ALU_AND ? a & b :
               fn == ALU_XOR ? a ^ b :
               fn == ALU_NOT ? ~b :
               fn == ALU_ROR ? {b[0], b[DW-1:1]} : {b[DW-2:0], b[DW-1]};
        cout = (fn == ALU_ADD || fn == ALU_INC) && sum[DW];
    end

endmodule

// File: rtl/tiny_cpu_core.sv
// tiny_cpu_core: single-cycle DW-bit teaching CPU with editable program memory
// Ports: clk/rst; step_en/run/step_req/resume execution control; prog_* edit
// and display port; reg_rsel/reg_rdata register display; out_port (r6), pc,
// carry, halted status.
module tiny_cpu_core
    import tiny_cpu_pkg::*;
#(
    parameter int DW = 4,
    parameter int AW = 4,
    localparam int IMW = imw_f(DW, AW),
    localparam int IW = 4 + IMW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_en,
    input  logic          run,
    input  logic          step_req,
    input  logic          resume,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_waddr,
    input  logic [IW-1:0] prog_wdata,
    input  logic [AW-1:0] prog_raddr,
    output logic [IW-1:0] prog_rdata,
    input  logic [2:0]    reg_rsel,
    output logic [DW-1:0] reg_rdata,
    output logic [DW-1:0] out_port,
    output logic [AW-1:0] pc,
    output logic          carry,
    output logic          halted
);

    logic [IW-1:0] mem_q [2**AW];
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic [AW-1:0] pc_q, pc_d;
    logic          carry_q, carry_d, halted_q, halted_d;
    logic [IW-1:0] instr;
    logic [3:0]    op;
    logic          sub, exec, alu_c;
    logic [2:0]    rd, rs;
    logic [DW-1:0] alu_y;

    assign instr = mem_q[pc_q];
    assign op    = instr[IW-1 -: 4];
    assign sub   = instr[IW-5];
    assign rd    = instr[5:3];
    assign rs    = instr[2:0];
    assign exec  = !halted_q && (run ? step_en : step_req);

    tiny_cpu_alu #(.DW(DW)) u_alu (
        .fn   (alu_fn_e'({op[1:0], sub})),
        .a    (regs_q[0]),
        .b    (regs_q[rs]),
        .y    (alu_y),
        .cout (alu_c)
    );

    always_comb begin
        regs_d   = regs_q;
        pc_d     = pc_q;
        carry_d  = carry_q;
        halted_d = halted_q;
        if (halted_q && resume) begin
            halted_d = 1'b0;
            pc_d     = pc_q + AW'(1);
        end else if (exec) begin
            pc_d = pc_q + AW'(1);
            if (op[3:2] == 2'b00) regs_d[rd] = regs_q[rs];
            else if (op[3:2] == 2'b01) begin
                regs_d[0] = alu_y;
                carry_d   = carry_q | alu_c;
            end
            else if (op == OP_JNC) begin
                pc_d    = carry_q ? pc_q + AW'(1) : instr[AW-1:0];
                carry_d = 1'b0;
            end
            else if (op == OP_JMP) pc_d = instr[AW-1:0];
            else if (op == OP_MVI) regs_d[0] = instr[DW-1:0];
            else if (op == OP_HLT) begin
                halted_d = 1'b1;
                pc_d     = pc_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q   <= '{default: '0};
            pc_q     <= '0;
            carry_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            pc_q     <= pc_d;
            carry_q  <= carry_d;
            halted_q <= halted_d;
        end
    end

    // Program memory survives reset; a write to mem[pc] lands after this
    // cycle's instruction has already been decoded from the old word.
    always_ff @(posedge clk) begin
        if (prog_we) mem_q[prog_waddr] <= prog_wdata;
    end

    assign prog_rdata = mem_q[prog_raddr];
    assign reg_rdata  = regs_q[reg_rsel];
    assign out_port   = regs_q[6];
    assign pc         = pc_q;
    assign carry      = carry_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_tiny_cpu_core.sv
// tb_tiny_cpu_core: directed tests for tiny_cpu_core at DW4/AW4 and DW8/AW6
module tb_tiny_cpu_core;

    logic clk = 1'b0, rst = 1'b0, step_en = 1'b0, run = 1'b0, step_req = 1'b0, resume = 1'b0;
    logic       a_we = 1'b0;
    logic [3:0] a_waddr = '0, a_raddr = '0, a_reg, a_out, a_pc;
    logic [7:0] a_wdata = '0, a_rdata;
    logic [2:0] a_rsel = '0;
    logic       a_carry, a_halt;
    logic        b_we = 1'b0;
    logic [5:0]  b_waddr = '0, b_raddr = '0, b_pc;
    logic [11:0] b_wdata = '0, b_rdata;
    logic [7:0]  b_reg, b_out;
    logic [2:0]  b_rsel = '0;
    logic        b_carry, b_halt;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    tiny_cpu_core #(.DW(4), .AW(4)) u4 (
        .clk(clk), .rst(rst), .step_en(step_en), .run(run), .step_req(step_req), .resume(resume),
        .prog_we(a_we), .prog_waddr(a_waddr), .prog_wdata(a_wdata), .prog_raddr(a_raddr),
        .prog_rdata(a_rdata), .reg_rsel(a_rsel), .reg_rdata(a_reg), .out_port(a_out),
        .pc(a_pc), .carry(a_carry), .halted(a_halt)
    );

    tiny_cpu_core #(.DW(8), .AW(6)) u8 (
        .clk(clk), .rst(rst), .step_en(step_en), .run(run), .step_req(step_req), .resume(resume),
        .prog_we(b_we), .prog_waddr(b_waddr), .prog_wdata(b_wdata), .prog_raddr(b_raddr),
        .prog_rdata(b_rdata), .reg_rsel(b_rsel), .reg_rdata(b_reg), .out_port(b_out),
        .pc(b_pc), .carry(b_carry), .halted(b_halt)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load4(input logic [3:0] addr, input logic [7:0] data);
        a_we = 1'b1; a_waddr = addr; a_wdata = data;
        tick();
        a_we = 1'b0;
    endtask

    task automatic load8(input logic [5:0] addr, input logic [11:0] data);
        b_we = 1'b1; b_waddr = addr; b_wdata = data;
        tick();
        b_we = 1'b0;
    endtask

    task automatic pulse_rst;
        run = 1'b0; step_en = 1'b0; step_req = 1'b0; resume = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_hlt_prog;
        load4(4'h0, 8'hA3); load4(4'h1, 8'h40); load4(4'h2, 8'h30); load4(4'h3, 8'hB0);
    endtask

    task automatic test_reset;
        pulse_rst();
        n_chk++; if (a_pc !== 4'h0) begin n_fail++; $display("FAIL reset_pc: got %0h want 0", a_pc); end
        n_chk++; if (a_halt !== 1'b0 || a_carry !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got halt=%0b carry=%0b want 0/0", a_halt, a_carry); end
        n_chk++; if (a_out !== 4'h0) begin n_fail++; $display("FAIL reset_out: got %0h want 0", a_out); end
    endtask

    task automatic test_run_hlt;
        load_hlt_prog();
        pulse_rst();
        run = 1'b1; step_en = 1'b1;
        tick(4);
        n_chk++; if (a_out !== 4'h6) begin n_fail++; $display("FAIL run_out: got %0h want 6", a_out); end
        n_chk++; if (a_pc !== 4'h3) begin n_fail++; $display("FAIL run_pc: got %0h want 3", a_pc); end
        n_chk++; if (a_halt !== 1'b1 || a_carry !== 1'b0) begin n_fail++; $display("FAIL run_flags: got halt=%0b carry=%0b want 1/0", a_halt, a_carry); end
        tick(2);
        n_chk++; if (a_pc !== 4'h3) begin n_fail++; $display("FAIL hlt_hold_pc: got %0h want 3", a_pc); end
        run = 1'b0; step_en = 1'b0;
    endtask

    task automatic test_jnc_jmp;
        load4(4'h0, 8'hAF); load4(4'h1, 8'h60); load4(4'h2, 8'h80); load4(4'h3, 8'h90);
        pulse_rst();
        a_rsel = 3'd0;
        run = 1'b1; step_en = 1'b1;
        tick(2);
        n_chk++; if (a_reg !== 4'h0 || a_carry !== 1'b1) begin n_fail++; $display("FAIL inc_wrap: got r0=%0h carry=%0b want 0/1", a_reg, a_carry); end
        tick();
        n_chk++; if (a_pc !== 4'h3 || a_carry !== 1'b0) begin n_fail++; $display("FAIL jnc_taken_carry: got pc=%0h carry=%0b want 3/0", a_pc, a_carry); end
        tick();
        n_chk++; if (a_pc !== 4'h0) begin n_fail++; $display("FAIL jmp: got pc=%0h want 0", a_pc); end
        run = 1'b0; step_en = 1'b0;
    endtask

    task automatic test_step;
        load_hlt_prog();
        pulse_rst();
        step_en = 1'b1;
        tick(3);
        step_en = 1'b0;
        n_chk++; if (a_pc !== 4'h0) begin n_fail++; $display("FAIL step_en_stopped: got pc=%0h want 0", a_pc); end
        for (int i = 1; i <= 3; i++) begin
            step_req = 1'b1; tick(); step_req = 1'b0; tick();
            n_chk++; if (a_pc !== 4'(i)) begin n_fail++; $display("FAIL step_req_pc: got %0h want %0h", a_pc, 4'(i)); end
        end
        step_req = 1'b1; tick(); step_req = 1'b0;
        n_chk++; if (a_pc !== 4'h3 || a_halt !== 1'b1) begin n_fail++; $display("FAIL step_hlt: got pc=%0h halt=%0b want 3/1", a_pc, a_halt); end
        step_req = 1'b1; tick(); step_req = 1'b0;
        n_chk++; if (a_pc !== 4'h3 || a_halt !== 1'b1) begin n_fail++; $display("FAIL step_while_halted: got pc=%0h halt=%0b want 3/1", a_pc, a_halt); end
        resume = 1'b1; step_req = 1'b1; tick(); resume = 1'b0; step_req = 1'b0;
        n_chk++; if (a_pc !== 4'h4 || a_halt !== 1'b0) begin n_fail++; $display("FAIL resume: got pc=%0h halt=%0b want 4/0", a_pc, a_halt); end
        resume = 1'b1; tick(); resume = 1'b0;
        n_chk++; if (a_pc !== 4'h4) begin n_fail++; $display("FAIL resume_ignored: got pc=%0h want 4", a_pc); end
        run = 1'b1; step_req = 1'b1; tick(); step_req = 1'b0; run = 1'b0;
        n_chk++; if (a_pc !== 4'h4) begin n_fail++; $display("FAIL step_req_in_run: got pc=%0h want 4", a_pc); end
    endtask

    task automatic test_carry_sticky;
        load4(4'h0, 8'hA9); load4(4'h1, 8'h08); load4(4'h2, 8'h41);
        load4(4'h3, 8'hA1); load4(4'h4, 8'h40); load4(4'h5, 8'hB0);
        pulse_rst();
        run = 1'b1; step_en = 1'b1;
        tick(3);
        a_rsel = 3'd1; #1;
        n_chk++; if (a_reg !== 4'h9) begin n_fail++; $display("FAIL mov_r1: got %0h want 9", a_reg); end
        a_rsel = 3'd0; #1;
        n_chk++; if (a_reg !== 4'h2 || a_carry !== 1'b1) begin n_fail++; $display("FAIL add_ovf: got r0=%0h carry=%0b want 2/1", a_reg, a_carry); end
        tick(2);
        n_chk++; if (a_reg !== 4'h2 || a_carry !== 1'b1) begin n_fail++; $display("FAIL carry_sticky: got r0=%0h carry=%0b want 2/1", a_reg, a_carry); end
        run = 1'b0; step_en = 1'b0;
    endtask

    task automatic test_wide;
        load8(6'h00, 12'hAC8); load8(6'h01, 12'h780); load8(6'h02, 12'h93F); load8(6'h3F, 12'hC00);
        pulse_rst();
        b_rsel = 3'd0;
        run = 1'b1; step_en = 1'b1;
        tick();
        n_chk++; if (b_reg !== 8'hC8) begin n_fail++; $display("FAIL wide_mvi: got %0h want c8", b_reg); end
        tick();
        n_chk++; if (b_reg !== 8'h91) begin n_fail++; $display("FAIL wide_rol: got %0h want 91", b_reg); end
        tick();
        n_chk++; if (b_pc !== 6'h3F) begin n_fail++; $display("FAIL wide_jmp: got %0h want 3f", b_pc); end
        tick();
        n_chk++; if (b_pc !== 6'h00) begin n_fail++; $display("FAIL wide_pc_wrap: got %0h want 0", b_pc); end
        run = 1'b0; step_en = 1'b0;
    endtask

    task automatic test_edit_and_rst;
        load4(4'h0, 8'hA5); load4(4'h1, 8'h90);
        pulse_rst();
        a_rsel = 3'd0; a_raddr = 4'h0;
        step_req = 1'b1; a_we = 1'b1; a_waddr = 4'h0; a_wdata = 8'hA7;
        tick();
        step_req = 1'b0; a_we = 1'b0;
        n_chk++; if (a_reg !== 4'h5 || a_pc !== 4'h1) begin n_fail++; $display("FAIL edit_old_word: got r0=%0h pc=%0h want 5/1", a_reg, a_pc); end
        n_chk++; if (a_rdata !== 8'hA7) begin n_fail++; $display("FAIL edit_written: got %0h want a7", a_rdata); end
        step_req = 1'b1; tick(); step_req = 1'b0; tick();
        step_req = 1'b1; tick(); step_req = 1'b0;
        n_chk++; if (a_reg !== 4'h7 || a_pc !== 4'h1) begin n_fail++; $display("FAIL edit_new_word: got r0=%0h pc=%0h want 7/1", a_reg, a_pc); end
        run = 1'b1; step_en = 1'b1;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        run = 1'b0; step_en = 1'b0;
        n_chk++; if (a_pc !== 4'h0 || a_reg !== 4'h0 || a_carry !== 1'b0 || a_halt !== 1'b0) begin n_fail++; $display("FAIL midrun_rst: got pc=%0h r0=%0h carry=%0b halt=%0b want 0/0/0/0", a_pc, a_reg, a_carry, a_halt); end
        n_chk++; if (a_rdata !== 8'hA7) begin n_fail++; $display("FAIL mem_kept: got %0h want a7", a_rdata); end
    endtask

    initial begin
        test_reset();
        test_run_hlt();
        test_jnc_jmp();
        test_step();
        test_carry_sticky();
        test_wide();
        test_edit_and_rst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
